// File: rtl/seno_sequencer.sv
// Sine-table address generator and registered valid/ready sample streamer for dmem_seno.
// Optional SENO_SEQ_BOUNCE_EN: reflect the index at the table ends instead of wrapping.
module seno_sequencer #(
  parameter int unsigned DEPTH  = 8100,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       base,
  input  logic [STEP_W-1:0] step,
  input  logic [31:0]       count,
  output logic [31:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_rd,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
`ifdef SENO_SEQ_BOUNCE_EN
  localparam logic [ADDR_W-1:0] TWICE_LAST_A = ADDR_W'(2 * (DEPTH - 1));
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_adv, step_q, step_ext, sum;
  logic [31:0]       cnt;
  logic              cont;
  logic              accept, load, last_load, drain_acc;
`ifdef SENO_SEQ_BOUNCE_EN
  logic              dir, dir_adv;  // 0 = up, 1 = down
`endif

  assign rom_addr = idx;

  // Next-state and datapath advance
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    last_load = 1'b0;
    drain_acc = 1'b0;
    step_ext  = ADDR_W'(step);
    sum       = idx + step_q;
    idx_adv   = sum;
`ifdef SENO_SEQ_BOUNCE_EN
    dir_adv   = dir;
    if (!dir) begin
      if (sum > LAST_A) begin
        idx_adv = TWICE_LAST_A - sum;
        dir_adv = 1'b1;
      end
    end else if (idx < step_q) begin
      idx_adv = step_q - idx;
      dir_adv = 1'b0;
    end else begin
      idx_adv = idx - step_q;
    end
`else
    if (sum >= DEPTH_A) idx_adv = sum - DEPTH_A;
`endif

    case (state)
      IDLE: begin
        accept = start && !stop;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        load      = !stop && (!sample_valid || sample_ready);
        last_load = load && !cont && (cnt == 32'd1);
        if (last_load) state_nxt = DRAIN;
      end
      DRAIN: begin
        drain_acc = !stop && sample_valid && sample_ready;
        if (drain_acc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (stop) state_nxt = IDLE;
  end

  // State, run parameters and sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      step_q       <= '0;
      cnt          <= '0;
      cont         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef SENO_SEQ_BOUNCE_EN
      dir          <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= drain_acc;

      if (accept) begin
        idx    <= base % DEPTH_A;
        step_q <= (step_ext >= DEPTH_A) ? LAST_A : step_ext;
        cnt    <= count;
        cont   <= (count == 32'd0);
`ifdef SENO_SEQ_BOUNCE_EN
        dir    <= 1'b0;
`endif
      end

      if (stop || drain_acc) begin
        sample_valid <= 1'b0;
      end else if (load) begin
        sample       <= rom_rd;
        sample_valid <= 1'b1;
        idx          <= idx_adv;
        if (!cont) cnt <= cnt - 32'd1;
`ifdef SENO_SEQ_BOUNCE_EN
        dir          <= dir_adv;
`endif
      end
    end
  end

endmodule
